// File: rtl/serial_frame_deserializer.sv
// Frames a bit-enabled serial stream (start, WIDTH data MSB first, even parity, stop=0)
// into a single-entry valid/ready output register with one-cycle error/overrun pulses.
module serial_frame_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             bit_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_word;
    logic [CW-1:0]    r_cnt;
    logic             r_par_bad;
    logic             r_valid;
    logic             r_perr;
    logic             r_ferr;
    logic             r_ovr;

    logic             w_cnt_clr;
    logic             w_shift;
    logic             w_par_cap;
    logic             w_good;
    logic             w_perr;
    logic             w_ferr;
    logic             w_load;
    logic             w_ovr;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_shift     = 1'b0;
        w_par_cap   = 1'b0;
        w_good      = 1'b0;
        w_perr      = 1'b0;
        w_ferr      = 1'b0;
        if (bit_en) begin
            case (r_state)
                S_IDLE: begin
                    if (bit_in) begin
                        w_state_nxt = S_DATA;
                        w_cnt_clr   = 1'b1;
                    end
                end
                S_DATA: begin
                    w_shift = 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_PARITY;
                end
                S_PARITY: begin
                    w_par_cap   = 1'b1;
                    w_state_nxt = S_STOP;
                end
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    // A bad stop bit outranks a bad parity bit.
                    if (bit_in)         w_ferr = 1'b1;
                    else if (r_par_bad) w_perr = 1'b1;
                    else                w_good = 1'b1;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // A same-edge accept frees the register, so back-to-back words see no gap.
    assign w_load = w_good & (~r_valid | word_ready);
    assign w_ovr  = w_good & r_valid & ~word_ready;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state   <= S_IDLE;
            r_sh      <= '0;
            r_cnt     <= '0;
            r_par_bad <= 1'b0;
            r_word    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_perr  <= w_perr;
            r_ferr  <= w_ferr;
            r_ovr   <= w_ovr;
            if (w_cnt_clr) r_cnt <= '0;
            else if (w_shift) r_cnt <= r_cnt + CW'(1);
            if (w_shift) r_sh <= {r_sh[WIDTH-2:0], bit_in};
            if (w_par_cap) r_par_bad <= (^r_sh) ^ bit_in;
            if (w_load) begin
                r_word  <= r_sh;
                r_valid <= 1'b1;
            end else if (r_valid && word_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign word_out   = r_word;
    assign word_valid = r_valid;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;
endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Bench for serial_frame_deserializer: frame-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_serial_frame_deserializer;
    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             clr_n = 1'b0;
    logic             bit_in = 1'b0;
    logic             bit_en = 1'b0;
    logic             word_ready = 1'b0;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             parity_err;
    logic             frame_err;
    logic             overrun;

    int total = 0;
    int bad = 0;

    int perr_cnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int valid_cnt = 0;
    int gap_cnt = 0;

    serial_frame_deserializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .bit_in     (bit_in),
        .bit_en     (bit_en),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: after a start bit, gather WIDTH+2 sampled bits, then judge the whole frame.
    logic [WIDTH-1:0] m_word = '0;
    logic             m_valid = 1'b0;
    logic             m_perr = 1'b0;
    logic             m_ferr = 1'b0;
    logic             m_ovr = 1'b0;
    bit               m_busy = 1'b0;
    bit               m_q[$];

    always @(posedge clk or negedge clr_n) begin
        logic [WIDTH-1:0] fw;
        logic             par;
        logic             good;
        if (!clr_n) begin
            m_word = '0; m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            m_busy = 1'b0;
            m_q.delete();
        end else begin
            m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            good = 1'b0;
            fw = '0;
            if (bit_en) begin
                if (!m_busy) begin
                    m_busy = bit_in;
                end else begin
                    m_q.push_back(bit_in);
                    if (m_q.size() == WIDTH + 2) begin
                        for (int i = 0; i < WIDTH; i++) fw = (fw << 1) | WIDTH'(m_q[i]);
                        par = m_q[WIDTH];
                        for (int i = 0; i < WIDTH; i++) par = par ^ fw[i];
                        if (m_q[WIDTH+1]) m_ferr = 1'b1;
                        else if (par)     m_perr = 1'b1;
                        else              good = 1'b1;
                        m_q.delete();
                        m_busy = 1'b0;
                    end
                end
            end
            if (good) begin
                if (!m_valid || word_ready) begin
                    m_word  = fw;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && word_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_word_out",   word_out,   m_word);
        check("cyc_word_valid", word_valid, m_valid);
        check("cyc_parity_err", parity_err, m_perr);
        check("cyc_frame_err",  frame_err,  m_ferr);
        check("cyc_overrun",    overrun,    m_ovr);
        perr_cnt  += int'(parity_err);
        ferr_cnt  += int'(frame_err);
        ovr_cnt   += int'(overrun);
        valid_cnt += int'(word_valid);
        gap_cnt   += int'(!word_valid);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        perr_cnt = 0; ferr_cnt = 0; ovr_cnt = 0; valid_cnt = 0; gap_cnt = 0;
    endtask

    // Sends the n bits of 'bits' starting at bit n-1; each bit waits 'gap'-1 disabled cycles first.
    task automatic send_bits(input logic [15:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            for (int g = 1; g < gap; g++) begin
                bit_en = 1'b0;
                bit_in = 1'($urandom_range(0, 1));
                cyc();
            end
            bit_en = 1'b1;
            bit_in = bits[i];
            cyc();
        end
        bit_en = 1'b0;
        bit_in = 1'b0;
    endtask

    task automatic idle(input int n);
        bit_en = 1'b0;
        bit_in = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_word_out", word_out, 0);
        check("rst_valid", word_valid, 0);
        check("rst_errs", {parity_err, frame_err, overrun}, 0);
        clr_n = 1'b1;
        cyc();

        // 1: good frame 0xA
        clear_counts();
        word_ready = 1'b1;
        send_bits(16'b1101000, 7, 1);
        check("s1_word", word_out, 4'hA);
        check("s1_valid", word_valid, 1);
        idle(3);
        check("s1_valid_cycles", valid_cnt, 1);
        check("s1_errs", perr_cnt + ferr_cnt + ovr_cnt, 0);

        // 2: parity wrong, stop wrong, both wrong
        clear_counts();
        send_bits(16'b1101010, 7, 1);
        idle(2);
        check("s2a_perr", perr_cnt, 1);
        check("s2a_ferr", ferr_cnt, 0);
        send_bits(16'b1101001, 7, 1);
        idle(2);
        check("s2b_ferr", ferr_cnt, 1);
        check("s2b_perr", perr_cnt, 1);
        send_bits(16'b1101011, 7, 1);
        idle(2);
        check("s2c_ferr", ferr_cnt, 2);
        check("s2c_perr", perr_cnt, 1);
        check("s2_valid_cycles", valid_cnt, 0);

        // 3: overrun while holding 0xA
        clear_counts();
        word_ready = 1'b0;
        send_bits(16'b1101000, 7, 1);
        send_bits(16'b1010100, 7, 1);
        idle(1);
        check("s3_word", word_out, 4'hA);
        check("s3_valid", word_valid, 1);
        check("s3_ovr", ovr_cnt, 1);
        word_ready = 1'b1;
        cyc();
        check("s3_drain", word_valid, 0);

        // 4: accept on the same edge as the next delivery
        word_ready = 1'b0;
        send_bits(16'b1101000, 7, 1);
        clear_counts();
        send_bits(16'b100110, 6, 1);
        word_ready = 1'b1;
        bit_en = 1'b1;
        bit_in = 1'b0;
        cyc();
        check("s4_word", word_out, 4'h3);
        check("s4_valid", word_valid, 1);
        check("s4_ovr", ovr_cnt, 0);
        check("s4_gap", gap_cnt, 0);
        idle(2);
        check("s4_drain", word_valid, 0);

        // 5: async reset mid-frame with a word held
        word_ready = 1'b0;
        send_bits(16'b1101000, 7, 1);
        send_bits(16'b110, 3, 1);
        #2;
        clr_n = 1'b0;
        #1;
        check("s5_rst_valid", word_valid, 0);
        check("s5_rst_word", word_out, 0);
        repeat (2) @(posedge clk);
        #3;
        clr_n = 1'b1;
        cyc();
        clear_counts();
        word_ready = 1'b1;
        send_bits(16'b1001100, 7, 1);
        check("s5_word", word_out, 4'h3);
        check("s5_valid", word_valid, 1);
        idle(2);
        check("s5_errs", perr_cnt + ferr_cnt + ovr_cnt, 0);

        // 6: sparse bit_en, leading zeros, noise on disabled cycles
        clear_counts();
        send_bits(16'b001101000, 9, 3);
        check("s6_word", word_out, 4'hA);
        check("s6_valid", word_valid, 1);
        idle(3);
        check("s6_valid_cycles", valid_cnt, 1);
        check("s6_errs", perr_cnt + ferr_cnt + ovr_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
